// File: rtl/io_egress_pkg.sv
// Shared types and constants for the fabric-to-pad egress FIFO.
package io_egress_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 4;
  localparam int STALL_CNT_W        = 8;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/io_egress_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one async read port.
module io_egress_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; occupancy tracking decides what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/io_egress_fifo.sv
// Fabric-to-pad first-word-fall-through egress FIFO with independent valid/ready sides.
// Optional IO_EGRESS_STALL_CNT_EN adds an 8-bit saturating fabric-stall counter output.
module io_egress_fifo
  import io_egress_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic [DATA_WIDTH-1:0]  from_fabric,
  input  logic                   from_fabric_valid,
  output logic                   from_fabric_ready,
  output logic [DATA_WIDTH-1:0]  out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
`ifdef IO_EGRESS_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  push;
  logic                  pop;

  // Ready ignores out_ready on purpose: a full FIFO never accepts, even while draining.
  assign from_fabric_ready = ~rst & en & ~flush & (count_q != FULL_CNT);
  assign out_valid         = ~rst & en & (count_q != '0);
  assign out               = rst ? '0 : rdata;
  assign count             = count_q;

  assign push = from_fabric_valid & from_fabric_ready;
  assign pop  = out_valid & out_ready;

  io_egress_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(from_fabric),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (en) begin
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

`ifdef IO_EGRESS_STALL_CNT_EN
  logic stall_evt;

  assign stall_evt = en & from_fabric_valid & ~from_fabric_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (en & flush) begin
      stall_cnt <= '0;
    end else if (stall_evt && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_io_egress_fifo.sv
// Scoreboard bench for io_egress_fifo: queue-based reference model, directed plus random traffic.
module tb_io_egress_fifo;
  import io_egress_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic        clk               = 1'b0;
  logic        rst               = 1'b1;
  logic        en                = 1'b0;
  logic        flush             = 1'b0;
  word_t       from_fabric       = '0;
  logic        from_fabric_valid = 1'b0;
  logic        from_fabric_ready;
  word_t       out;
  logic        out_valid;
  logic        out_ready         = 1'b0;
  logic [2:0]  count;
`ifdef IO_EGRESS_STALL_CNT_EN
  logic [7:0]  stall_cnt;
`endif

  word_t mq[$];
  word_t got[$];
  word_t want[$];
  int    stall_exp  = 0;
  bit    model_push = 1'b0;
  int    errors     = 0;
  int    checks     = 0;

  always #5 clk = ~clk;

  io_egress_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .flush            (flush),
    .from_fabric      (from_fabric),
    .from_fabric_valid(from_fabric_valid),
    .from_fabric_ready(from_fabric_ready),
    .out              (out),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .count            (count)
`ifdef IO_EGRESS_STALL_CNT_EN
    ,
    .stall_cnt        (stall_cnt)
`endif
  );

  function automatic bit exp_ready();
    return !rst && en && !flush && (mq.size() < DEPTH);
  endfunction

  function automatic bit exp_valid();
    return !rst && en && (mq.size() > 0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered word list bounded at DEPTH, updated once per clock.
  always @(posedge clk) begin : model
    bit do_push;
    bit do_pop;
    do_push    = from_fabric_valid && exp_ready();
    do_pop     = out_ready && exp_valid();
    model_push = 1'b0;
    if (rst) begin
      mq.delete();
      stall_exp = 0;
    end else if (en) begin
      if (flush) begin
        mq.delete();
        stall_exp = 0;
      end else begin
        if (from_fabric_valid && !do_push && stall_exp < 255) stall_exp++;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          mq.push_back(from_fabric);
          model_push = 1'b1;
        end
      end
    end
  end

  // Monitor: compares every DUT output each cycle and logs words actually delivered.
  always @(negedge clk) begin
    checkOutput("ready", 32'(from_fabric_ready), 32'(exp_ready()));
    checkOutput("out_valid", 32'(out_valid), 32'(exp_valid()));
    checkOutput("count", 32'(count), rst ? 32'd0 : 32'(mq.size()));
    if (rst) checkOutput("out_reset", out, 32'd0);
    else if (exp_valid()) checkOutput("out_data", out, mq[0]);
`ifdef IO_EGRESS_STALL_CNT_EN
    checkOutput("stall_cnt", 32'(stall_cnt), rst ? 32'd0 : 32'(stall_exp));
`endif
    if (!rst && en && out_valid && out_ready) got.push_back(out);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit f, input bit v,
                               input word_t d, input bit ordy);
    rst               = r;
    en                = e;
    flush             = f;
    from_fabric_valid = v;
    from_fabric       = d;
    out_ready         = ordy;
  endtask

  task automatic step(input bit r, input bit e, input bit f, input bit v,
                      input word_t d, input bit ordy);
    tick();
    applyStimulus(r, e, f, v, d, ordy);
  endtask

  task automatic checkDelivered(input string name);
    checkOutput({name, "_len"}, 32'(got.size()), 32'(want.size()));
    for (int i = 0; i < want.size(); i++) begin
      if (i < got.size()) checkOutput(name, got[i], want[i]);
    end
    got.delete();
    want.delete();
  endtask

  initial begin
    int    sent;
    int    guard;
    bit    ordy;
    word_t word;

    applyStimulus(1, 0, 0, 0, '0, 0);
    repeat (2) tick();
    step(0, 1, 0, 0, '0, 0);

    step(0, 1, 0, 1, 32'hDEADBEEF, 0);
    repeat (3) step(0, 1, 0, 0, '0, 0);
    step(0, 1, 0, 0, '0, 1);
    step(0, 1, 0, 0, '0, 0);
    want = '{32'hDEADBEEF};
    checkDelivered("single");

    for (int i = 1; i <= 4; i++) step(0, 1, 0, 1, word_t'(i), 0);
    step(0, 1, 0, 1, 32'h5, 0);
    repeat (260) step(0, 1, 0, 1, 32'h6, 0);
    repeat (6) step(0, 1, 0, 0, '0, 1);
    want = '{32'h1, 32'h2, 32'h3, 32'h4};
    checkDelivered("fill");

    word  = 32'h100;
    sent  = 0;
    guard = 0;
    ordy  = 1'b1;
    step(0, 1, 0, 1, word, ordy);
    while (sent < 20 && guard < 200) begin
      tick();
      if (model_push) begin
        sent++;
        word++;
      end
      ordy = !ordy;
      applyStimulus(0, 1, 0, sent < 20, word, ordy);
      guard++;
    end
    checkOutput("stream_sent", 32'(sent), 32'd20);
    repeat (8) step(0, 1, 0, 0, '0, 1);
    for (int i = 0; i < 20; i++) want.push_back(word_t'(32'h100 + i));
    checkDelivered("stream");

    step(0, 1, 0, 1, 32'hA1, 0);
    step(0, 1, 0, 1, 32'hA2, 0);
    step(0, 1, 0, 1, 32'hA3, 1);
    repeat (4) step(0, 1, 0, 0, '0, 1);
    want = '{32'hA1, 32'hA2, 32'hA3};
    checkDelivered("simul");

    step(0, 1, 0, 1, 32'hF1, 0);
    step(0, 1, 0, 1, 32'hF2, 0);
    step(0, 1, 0, 1, 32'hF3, 0);
    step(0, 1, 1, 1, 32'hF4, 0);
    step(0, 1, 0, 1, 32'hA5, 0);
    step(0, 1, 0, 0, '0, 0);
    repeat (3) step(0, 1, 0, 0, '0, 1);
    want = '{32'hA5};
    checkDelivered("flush");

    step(0, 1, 0, 1, 32'hE1, 0);
    step(0, 1, 0, 1, 32'hE2, 0);
    step(0, 0, 0, 1, 32'hE3, 1);
    step(0, 0, 1, 1, 32'hE3, 1);
    step(0, 0, 0, 1, 32'hE3, 1);
    repeat (4) step(0, 1, 0, 0, '0, 1);
    want = '{32'hE1, 32'hE2};
    checkDelivered("enable");

    step(0, 1, 0, 1, 32'hC1, 0);
    step(0, 1, 0, 1, 32'hC2, 0);
    step(0, 1, 0, 1, 32'hC3, 0);
    step(1, 1, 0, 1, 32'hC4, 1);
    step(1, 1, 0, 0, '0, 1);
    repeat (3) step(0, 1, 0, 0, '0, 1);
    checkDelivered("reset");

    repeat (500) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
           word_t'($urandom), $urandom_range(0, 2) != 0);
    end
    repeat (6) step(0, 1, 0, 0, '0, 1);
    got.delete();

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
